// File: rtl/wb_bootrom_arbiter.sv
// rtl/wb_bootrom_arbiter.sv - two-master Wishbone arbiter in front of the boot ROM, with wait timeout
// Optional macro WB_BOOTROM_ARB_RR_EN: round-robin on simultaneous requests (default: m1 wins ties).
module wb_bootrom_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [15:0] cnt_q, cnt_d;

  logic req0, req1;
  logic g_cyc, g_stb;
  logic busy;
  logic timeout;

  assign req0  = m0_cyc_i & m0_stb_i;
  assign req1  = m1_cyc_i & m1_stb_i;
  assign g_cyc = grant_q ? m1_cyc_i : m0_cyc_i;
  assign g_stb = grant_q ? m1_stb_i : m0_stb_i;
  assign busy  = (state_q == BUSY);

  // Abort fires on the wait cycle where the counter has reached its last allowed value.
  assign timeout = busy & g_stb & ~s_ack_i & ~s_err_i & (cnt_q == TIMEOUT_LAST);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = busy & ~grant_q & s_ack_i;
  assign m1_ack_o = busy &  grant_q & s_ack_i;
  assign m0_err_o = busy & ~grant_q & (s_err_i | timeout);
  assign m1_err_o = busy &  grant_q & (s_err_i | timeout);

  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & g_stb;

  // Slave address/data/control mux: granted master while busy, otherwise m0.
  always_comb begin
    s_adr_o = m0_adr_i;
    s_we_o  = m0_we_i;
    s_sel_o = m0_sel_i;
    s_dat_o = m0_dat_i;
    if (busy && grant_q) begin
      s_adr_o = m1_adr_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Next-state logic: arbitration in IDLE, wait counting in BUSY, drain in ABORT.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = BUSY;
          cnt_d   = 16'd0;
`ifdef WB_BOOTROM_ARB_RR_EN
          if (req0 && req1) grant_d = ~grant_q;
          else              grant_d = req1;
`else
          grant_d = req1;
`endif
        end
      end
      BUSY: begin
        if (g_stb && !s_ack_i && !s_err_i) cnt_d = cnt_q + 16'd1;
        else                               cnt_d = 16'd0;
        if (!g_cyc) begin
          state_d = IDLE;
        end else if (timeout) begin
          state_d = ABORT;
          cnt_d   = 16'd0;
        end
      end
      ABORT: begin
        if (!g_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and wait counter registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_bootrom_arbiter.sv
// tb/tb_wb_bootrom_arbiter.sv - directed self-checking bench for wb_bootrom_arbiter
module tb_wb_bootrom_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
  logic [3:0]  m0_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [3:0]  m1_sel_i;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  logic [3:0]  s_sel_o;

  int total = 0;
  int bad   = 0;

`ifdef WB_BOOTROM_ARB_RR_EN
  localparam logic FIRST_M1 = 1'b0;
`else
  localparam logic FIRST_M1 = 1'b1;
`endif

  always #5 wb_clk_i = ~wb_clk_i;

  // ROM word n at byte address 4n reads back as 0xC0DE0000 | n.
  assign s_dat_i = 32'hC0DE0000 | {22'd0, s_adr_o[11:2]};

  wb_bootrom_arbiter #(.TIMEOUT(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tie_round(input string tag);
    m0_adr_i = 32'h0000_0000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_adr_i = 32'h0000_0020; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    chk({tag, "_first_adr"}, s_adr_o, FIRST_M1 ? 32'h20 : 32'h0);
    s_ack_i = 1'b1; #1;
    chk({tag, "_first_m0_ack"}, {31'd0, m0_ack_o}, {31'd0, ~FIRST_M1});
    chk({tag, "_first_m1_ack"}, {31'd0, m1_ack_o}, {31'd0, FIRST_M1});
    tick();
    s_ack_i = 1'b0;
    if (FIRST_M1) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
    else          begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
    tick();
    tick();
    chk({tag, "_second_adr"}, s_adr_o, FIRST_M1 ? 32'h0 : 32'h20);
    s_ack_i = 1'b1; #1;
    chk({tag, "_second_m0_ack"}, {31'd0, m0_ack_o}, {31'd0, FIRST_M1});
    chk({tag, "_second_m1_ack"}, {31'd0, m1_ack_o}, {31'd0, ~FIRST_M1});
    tick();
    s_ack_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
  endtask

  initial begin
    wb_rst_i = 1'b1;
    m0_adr_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_dat_i = '0;
    m1_adr_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'hF; m1_dat_i = '0;
    s_ack_i = 1'b1; s_err_i = 1'b0;
    tick();
    tick();
    chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_s_stb", {31'd0, s_stb_o}, 32'd0);
    chk("rst_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    chk("rst_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    wb_rst_i = 1'b0;
    s_ack_i = 1'b0;

    // Single read of word 4 by m0, ROM acks one cycle after the strobe.
    m0_adr_i = 32'h0000_0010; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; #1;
    chk("rd_idle_stb", {31'd0, s_stb_o}, 32'd0);
    tick();
    chk("rd_stb", {31'd0, s_stb_o}, 32'd1);
    chk("rd_adr", s_adr_o, 32'h10);
    chk("rd_no_ack_yet", {31'd0, m0_ack_o}, 32'd0);
    tick();
    s_ack_i = 1'b1; #1;
    chk("rd_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    chk("rd_m0_dat", m0_dat_o, 32'hC0DE0004);
    chk("rd_m1_dat", m1_dat_o, 32'hC0DE0004);
    chk("rd_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; #1;
    chk("rd_ack_one_cycle", {31'd0, m0_ack_o}, 32'd0);
    tick();
    chk("rd_idle_cyc", {31'd0, s_cyc_o}, 32'd0);

    // Ties straight out of reset, twice.
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    tie_round("tie1");
    tie_round("tie2");

    // Timeout with TIMEOUT = 4 and a silent slave.
    m0_adr_i = 32'h0000_0040; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    chk("to_wait1_err", {31'd0, m0_err_o}, 32'd0);
    tick();
    tick();
    chk("to_wait3_err", {31'd0, m0_err_o}, 32'd0);
    tick();
    chk("to_wait4_m0_err", {31'd0, m0_err_o}, 32'd1);
    chk("to_wait4_m1_err", {31'd0, m1_err_o}, 32'd0);
    chk("to_wait4_stb", {31'd0, s_stb_o}, 32'd1);
    tick();
    chk("to_abort_stb", {31'd0, s_stb_o}, 32'd0);
    chk("to_abort_err", {31'd0, m0_err_o}, 32'd0);
    s_ack_i = 1'b1; #1;
    chk("to_abort_ack_ignored", {31'd0, m0_ack_o}, 32'd0);
    s_ack_i = 1'b0;
    tick();
    chk("to_abort_held_cyc", {31'd0, s_cyc_o}, 32'd0);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // Lock: m1 holds cyc through three acked strobes while m0 waits.
    m1_adr_i = 32'h0000_0030; m1_we_i = 1'b1; m1_sel_i = 4'h3; m1_dat_i = 32'hDEADBEEF;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    m0_adr_i = 32'h0000_0050; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    s_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_m1_ack", {31'd0, m1_ack_o}, 32'd1);
      chk("lock_m0_ack", {31'd0, m0_ack_o}, 32'd0);
      chk("lock_s_dat", s_dat_o, 32'hDEADBEEF);
      chk("lock_s_we_sel", {27'd0, s_we_o, s_sel_o}, 32'h13);
      tick();
    end
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; #1;
    chk("lock_release_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    tick();
    chk("lock_idle_cyc", {31'd0, s_cyc_o}, 32'd0);
    tick();
    chk("lock_m0_adr", s_adr_o, 32'h50);
    chk("lock_m0_stb", {31'd0, s_stb_o}, 32'd1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();

    // Reset in the middle of a BUSY wait.
    m0_adr_i = 32'h0000_0080; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    chk("rw_busy_cyc", {31'd0, s_cyc_o}, 32'd1);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b1; #1;
    chk("rw_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rw_m0_ack_err", {30'd0, m0_ack_o, m0_err_o}, 32'd0);
    chk("rw_m1_ack_err", {30'd0, m1_ack_o, m1_err_o}, 32'd0);
    s_ack_i = 1'b0;
    m1_adr_i = 32'h0000_0024; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    chk("rw_m1_adr", s_adr_o, 32'h24);
    chk("rw_m1_stb", {31'd0, s_stb_o}, 32'd1);
    s_ack_i = 1'b1; #1;
    chk("rw_m1_ack", {31'd0, m1_ack_o}, 32'd1);
    chk("rw_m1_dat", m1_dat_o, 32'hC0DE0009);
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
